router_out_arbiter: RTL and testbench

Read-side scheduler for the 1x3 router. It drains the three router output FIFOs (data_out_0..2 / vld_out_0..2 / read_enb_0..2) onto one shared downstream byte stream. It grants one port at a time, round-robin, and keeps each packet atomic: header, payload and parity are never interleaved with another port's bytes. It sits between the router outputs and a single consumer that can apply backpressure.

---
 rtl/router_out_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_router_out_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_out_arbiter.sv
// Read-side scheduler for the 1x3 router: round-robin drains the three output FIFOs onto one
// byte stream, keeping each packet atomic, through a 2-entry skid buffer with credit control.
module router_out_arbiter #(
  parameter int unsigned DW          = 8,
  parameter int unsigned STALL_LIMIT = 30
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vld_out_0,
  input  logic          vld_out_1,
  input  logic          vld_out_2,
  input  logic [DW-1:0] data_out_0,
  input  logic [DW-1:0] data_out_1,
  input  logic [DW-1:0] data_out_2,
  output logic          read_enb_0,
  output logic          read_enb_1,
  output logic          read_enb_2,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_sop,
  output logic          m_eop,
  output logic [1:0]    m_port,
  output logic [2:0]    grant,
  output logic          stall_timeout
);

  localparam int unsigned CW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StHdr, StHdrWait, StBody} state_e;

  state_e        state_q, state_d;
  logic [1:0]    gidx_q, gidx_d;
  logic [2:0]    grant_q, grant_d;
  logic [1:0]    rr_q, rr_d;
  logic [6:0]    rem_q, rem_d;
  logic [CW-1:0] stall_q, stall_d;

  // Tags of the read issued last cycle; its data is on data_out_* this cycle.
  logic          pend_q, pend_sop_q, pend_eop_q;
  logic [1:0]    pend_port_q;

  logic [DW-1:0] buf_data_q [2];
  logic          buf_sop_q  [2];
  logic          buf_eop_q  [2];
  logic [1:0]    buf_port_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    cnt_q, cnt_d;

  logic [2:0]    vld;
  logic          g_vld;
  logic [DW-1:0] rdata;
  logic          pop, credit;
  logic [2:0]    occ;
  logic          rd, rd_sop, rd_eop;

  function automatic logic [1:0] inc3(logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // First requesting port at or after rr, in the order rr, rr+1, rr+2 (mod 3).
  function automatic logic [1:0] pick_port(logic [2:0] v, logic [1:0] rr);
    logic [1:0] p;
    logic [1:0] sel;
    sel = rr;
    p   = inc3(inc3(rr));
    for (int k = 0; k < 3; k++) begin
      if (v[p]) sel = p;
      p = (p == 2'd0) ? 2'd2 : p - 2'd1;
    end
    return sel;
  endfunction

  assign vld   = {vld_out_2, vld_out_1, vld_out_0};
  assign g_vld = vld[gidx_q];

  always_comb begin
    unique case (pend_port_q)
      2'd1:    rdata = data_out_1;
      2'd2:    rdata = data_out_2;
      default: rdata = data_out_0;
    endcase
  end

  assign m_valid = (cnt_q != 2'd0);
  assign pop     = m_valid & m_ready;
  assign occ     = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, pop};
  assign credit  = (occ < 3'd2);
  assign cnt_d   = cnt_q + {1'b0, pend_q} - {1'b0, pop};

  always_comb begin
    state_d       = state_q;
    gidx_d        = gidx_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    rem_d         = rem_q;
    stall_d       = stall_q;
    rd            = 1'b0;
    rd_sop        = 1'b0;
    rd_eop        = 1'b0;
    stall_timeout = 1'b0;

    unique case (state_q)
      StIdle: begin
        stall_d = '0;
        if (|vld) begin
          gidx_d  = pick_port(vld, rr_q);
          grant_d = 3'b001 << pick_port(vld, rr_q);
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (g_vld && credit) begin
          rd      = 1'b1;
          rd_sop  = 1'b1;
          state_d = StHdrWait;
        end
      end
      StHdrWait: begin
        rem_d   = 7'(rdata >> 2) + 7'd1;
        state_d = StBody;
      end
      StBody: begin
        if (rem_q != 7'd0 && g_vld && credit) begin
          rd    = 1'b1;
          rem_d = rem_q - 7'd1;
          if (rem_q == 7'd1) begin
            rd_eop  = 1'b1;
            rr_d    = inc3(gidx_q);
            grant_d = 3'b000;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Only an empty granted FIFO counts toward the stall; credit stalls do not.
    if (state_q == StHdr || state_q == StBody) begin
      if (g_vld) begin
        stall_d = '0;
      end else if (stall_q == CW'(STALL_LIMIT - 1)) begin
        stall_timeout = 1'b1;
        stall_d       = '0;
        rr_d          = inc3(gidx_q);
        grant_d       = 3'b000;
        state_d       = StIdle;
      end else begin
        stall_d = stall_q + 1'b1;
      end
    end
  end

  assign read_enb_0 = rd & (gidx_q == 2'd0);
  assign read_enb_1 = rd & (gidx_q == 2'd1);
  assign read_enb_2 = rd & (gidx_q == 2'd2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      gidx_q      <= 2'd0;
      grant_q     <= 3'b000;
      rr_q        <= 2'd0;
      rem_q       <= 7'd0;
      stall_q     <= '0;
      pend_q      <= 1'b0;
      pend_sop_q  <= 1'b0;
      pend_eop_q  <= 1'b0;
      pend_port_q <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_sop_q[i]  <= 1'b0;
        buf_eop_q[i]  <= 1'b0;
        buf_port_q[i] <= 2'd0;
      end
    end else begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      rem_q       <= rem_d;
      stall_q     <= stall_d;
      pend_q      <= rd;
      pend_sop_q  <= rd_sop;
      pend_eop_q  <= rd_eop;
      pend_port_q <= gidx_q;
      cnt_q       <= cnt_d;
      if (pend_q) begin
        buf_data_q[wr_ptr_q] <= rdata;
        buf_sop_q[wr_ptr_q]  <= pend_sop_q;
        buf_eop_q[wr_ptr_q]  <= pend_eop_q;
        buf_port_q[wr_ptr_q] <= pend_port_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign m_data = m_valid ? buf_data_q[rd_ptr_q] : '0;
  assign m_sop  = m_valid & buf_sop_q[rd_ptr_q];
  assign m_eop  = m_valid & buf_eop_q[rd_ptr_q];
  assign m_port = m_valid ? buf_port_q[rd_ptr_q] : 2'd0;
  assign grant  = grant_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Bench for router_out_arbiter: FIFO models feed packets, a scoreboard checks every output byte.
module tb_router_out_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       vld_out_0 = 1'b0, vld_out_1 = 1'b0, vld_out_2 = 1'b0;
  logic [7:0] data_out_0 = '0, data_out_1 = '0, data_out_2 = '0;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] m_data;
  logic       m_valid, m_sop, m_eop, stall_timeout;
  logic       m_ready = 1'b1;
  logic [1:0] m_port;
  logic [2:0] grant;

  router_out_arbiter #(.DW(8), .STALL_LIMIT(30)) dut (
    .clock(clock), .reset(reset),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop),
    .m_port(m_port), .grant(grant), .stall_timeout(stall_timeout)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic [1:0] port;
  } beat_t;

  typedef struct packed {
    logic       rst;
    logic [1:0] n;
    logic [5:0] port_order;  // emission order, first port in [1:0]
    logic [5:0] len;
    logic [1:0] mode;        // 0 ready, 1 toggle, 2 random, 3 stalled
  } vec_t;

  beat_t      sb[$];
  beat_t      mon_e;
  logic [7:0] fq0[$], fq1[$], fq2[$];
  int         tests = 0, fails = 0;
  int         rd_cnt[3], exp_rd[3];
  int         n_timeout = 0, xfers = 0, ready_mode = 0;
  vec_t       vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input int p, input logic [7:0] b);
    case (p)
      0: fq0.push_back(b);
      1: fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
  endtask

  // keep < 0 pushes the whole packet; otherwise only the first keep bytes.
  task automatic add_packet(input int p, input int len, input int keep);
    int         total;
    logic [7:0] b, par;
    beat_t      e;
    total = len + 2;
    if (keep < 0) keep = total;
    par = '0;
    for (int i = 0; i < total; i++) begin
      if (i == 0) b = {6'(len), 2'(p)};
      else if (i == total - 1) b = par;
      else b = 8'($urandom);
      par = par ^ b;
      if (i < keep) begin
        push_byte(p, b);
        e.d = b; e.sop = (i == 0); e.eop = (i == total - 1); e.port = 2'(p);
        sb.push_back(e);
        exp_rd[p]++;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete(); fq0.delete(); fq1.delete(); fq2.delete();
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic clear_counts();
    for (int p = 0; p < 3; p++) begin rd_cnt[p] = 0; exp_rd[p] = 0; end
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((sb.size() != 0 || m_valid) && k < budget) begin tick(1); k++; end
    check(name, sb.size(), 0);
  endtask

  task automatic check_reads(input string name);
    for (int p = 0; p < 3; p++) check($sformatf("%s_rd_p%0d", name, p), rd_cnt[p], exp_rd[p]);
  endtask

  // Router FIFO model: data follows read_enb by one cycle; also drives m_ready.
  initial begin
    logic rd0, rd1, rd2;
    forever begin
      @(negedge clock);
      rd0 = read_enb_0; rd1 = read_enb_1; rd2 = read_enb_2;
      @(posedge clock);
      #1;
      if (rd0 && fq0.size() != 0) data_out_0 = fq0.pop_front();
      if (rd1 && fq1.size() != 0) data_out_1 = fq1.pop_front();
      if (rd2 && fq2.size() != 0) data_out_2 = fq2.pop_front();
      vld_out_0 = (fq0.size() != 0);
      vld_out_1 = (fq1.size() != 0);
      vld_out_2 = (fq2.size() != 0);
      case (ready_mode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: pops the scoreboard on each accepted byte.
  always @(negedge clock) begin
    if (!reset) begin
      check("rd_onehot", 32'($countones({read_enb_2, read_enb_1, read_enb_0}) <= 1), 1);
      rd_cnt[0] += int'(read_enb_0);
      rd_cnt[1] += int'(read_enb_1);
      rd_cnt[2] += int'(read_enb_2);
      if (stall_timeout) n_timeout++;
      if (m_valid && m_ready) begin
        xfers++;
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_byte: got %0h expected no byte", m_data);
        end else begin
          mon_e = sb.pop_front();
          check("byte", 32'({m_data, m_sop, m_eop, m_port}), 32'(mon_e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   t_v, t_r, t_m, x0, k;

    vecs[0] = '{1'b1, 2'd1, 6'b00_00_01, 6'd3,  2'd0};  // port 1, L=3
    vecs[1] = '{1'b0, 2'd2, 6'b00_00_10, 6'd1,  2'd0};  // rr_ptr=2: port 2 before 0
    vecs[2] = '{1'b1, 2'd3, 6'b10_01_00, 6'd2,  2'd0};  // all ports after reset
    vecs[3] = '{1'b0, 2'd1, 6'b00_00_10, 6'd0,  2'd0};  // L=0
    vecs[4] = '{1'b0, 2'd1, 6'b00_00_01, 6'd10, 2'd1};  // m_ready toggling
    vecs[5] = '{1'b0, 2'd1, 6'b00_00_00, 6'd5,  2'd2};  // random backpressure
    vecs[6] = '{1'b0, 2'd2, 6'b00_00_01, 6'd63, 2'd2};  // rr_ptr=1: port 1 before 0

    #3;
    check("reset_outputs", 32'({read_enb_2, read_enb_1, read_enb_0, m_data, m_valid, m_sop,
                                m_eop, m_port, grant, stall_timeout}), 0);
    tick(2);
    reset = 1'b0;
    tick(1);

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      if (v.rst) do_reset();
      ready_mode = int'(v.mode);
      clear_counts();
      for (int j = 0; j < int'(v.n); j++) add_packet(int'(v.port_order[2*j +: 2]), int'(v.len), -1);
      drain($sformatf("vec%0d_drain", i), 2000);
      check_reads($sformatf("vec%0d", i));
      check($sformatf("vec%0d_grant_idle", i), 32'(grant), 0);
    end

    // Backpressure: only two bytes may be fetched while m_ready is held low.
    do_reset();
    ready_mode = 3;
    clear_counts();
    tick(1);
    add_packet(0, 5, -1);
    tick(20);
    check("bp_reads", rd_cnt[0], 2);
    check("bp_head", 32'({m_valid, m_sop, m_data}), 32'({1'b1, 1'b1, 8'h14}));
    ready_mode = 0;
    drain("bp_drain", 200);
    check_reads("bp");

    // Stall: port 1 dries up after two payload bytes; port 2 must follow after the timeout.
    do_reset();
    clear_counts();
    n_timeout = 0;
    add_packet(1, 5, 3);
    add_packet(2, 1, -1);
    drain("stall_drain", 200);
    check("stall_timeouts", n_timeout, 1);
    check_reads("stall");

    // Asynchronous reset three bytes into a packet.
    do_reset();
    clear_counts();
    x0 = xfers;
    add_packet(0, 8, -1);
    k = 0;
    while (xfers < x0 + 3 && k < 50) begin tick(1); k++; end
    check("rst_mid_progress", 32'(xfers >= x0 + 3), 1);
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", 32'({read_enb_2, read_enb_1, read_enb_0, m_data, m_valid, m_sop,
                                  m_eop, m_port, grant, stall_timeout}), 0);
    sb.delete(); fq0.delete(); fq1.delete(); fq2.delete();
    tick(2);
    reset = 1'b0;
    tick(1);
    clear_counts();
    add_packet(0, 1, -1);
    t_v = -1; t_r = -1; t_m = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (vld_out_0 && t_v < 0) t_v = c;
      if (read_enb_0 && t_r < 0) t_r = c;
      if (m_valid && t_m < 0) t_m = c;
    end
    check("lat_vld_to_rd", t_r - t_v, 1);
    check("lat_rd_to_data", t_m - t_r, 2);
    tick(1);
    drain("post_rst_drain", 100);
    check_reads("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
